// File: rtl/fusion_pipe_pkg.sv
// ---------------------------------------------------------------------------
// fusion_pipe_pkg
//  Shared constants and types for the decode/issue pipeline slice.
//  - NUM_REGS / REG_AW : architectural register file geometry
//  - CNT_W             : width of the post-branch flush counter (holds 1..7)
//  - issue_state_e     : issue controller FSM encoding
//  - reg_onehot()      : register address to one-hot vector, r0 always masked
// ---------------------------------------------------------------------------
package fusion_pipe_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } issue_state_e;

    // r0 is hard-wired, so it never appears in a set or clear vector.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en,
                                                       input logic [REG_AW-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec = '0;
        if (en && (addr != '0)) begin
            vec[addr] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_32_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//  Pending-write scoreboard: one bit per architectural register, set when an
//  instruction writing that register issues, cleared when its writeback
//  retires. Three combinational read ports see the writeback-bypassed view
//  when WB_BYPASS=1.
// Ports
//  clk_in, reset_in          clock, async active-low reset
//  set_valid, set_rd         issuing instruction's destination
//  wb_valid, wb_rd           retiring writeback destination
//  rd_a, rd_b, rd_c          read port addresses
//  hit_a, hit_b, hit_c       register pending (effective view)
//  pending                   raw scoreboard vector
//  pending_post_wb           scoreboard with this cycle's writeback removed
// ---------------------------------------------------------------------------
module reg_scoreboard
    import fusion_pipe_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                set_valid,
    input  logic [REG_AW-1:0]   set_rd,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [REG_AW-1:0]   rd_a,
    input  logic [REG_AW-1:0]   rd_b,
    input  logic [REG_AW-1:0]   rd_c,
    output logic                hit_a,
    output logic                hit_b,
    output logic                hit_c,
    output logic [NUM_REGS-1:0] pending,
    output logic [NUM_REGS-1:0] pending_post_wb
);

    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] pend_eff;

    assign wb_clr          = reg_onehot(wb_valid, wb_rd);
    assign set_vec         = reg_onehot(set_valid, set_rd);
    assign pending_post_wb = pending & ~wb_clr;
    assign pend_eff        = WB_BYPASS ? pending_post_wb : pending;

    // Bit 0 is never set, so r0 reads always return 0.
    assign hit_a = pend_eff[rd_a];
    assign hit_b = pend_eff[rd_b];
    assign hit_c = pend_eff[rd_c];

    // Clear is applied first so a same-register issue in the wb cycle
    // leaves the bit set for the newer writer.
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            pending <= '0;
        end else begin
            pending <= pending_post_wb | set_vec;
        end
    end

endmodule

// File: rtl/decode_issue_ctrl_32.sv
// ---------------------------------------------------------------------------
// decode_issue_ctrl_32
//  Issue/hazard controller between decode_32 and execute. Stalls decode on
//  RAW/WAW hazards against the register scoreboard, drains outstanding
//  writes before memsync/syscall, and suppresses issue for FLUSH_CYCLES
//  after a taken PC change.
// Ports
//  clk_in, reset_in        clock, async active-low reset
//  dec_*_in                decoded instruction (valid, sources, dest, sync kinds)
//  wb_valid_in, wb_rd_in   writeback retiring a register write
//  pc_taken_in             execute resolved a taken branch/jump
//  stall_out               hold the instruction in decode (combinational)
//  issue_valid_out         instruction accepted into execute (combinational)
//  flush_out               registered one-cycle squash pulse
//  drain_busy_out          FSM is in DRAIN
//  pending_out             scoreboard vector
// ---------------------------------------------------------------------------
module decode_issue_ctrl_32
    import fusion_pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          WB_BYPASS    = 1'b1
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                dec_valid_in,
    input  logic [REG_AW-1:0]   dec_rsa_in,
    input  logic [REG_AW-1:0]   dec_rsb_in,
    input  logic [REG_AW-1:0]   dec_rd_in,
    input  logic                dec_memsync_in,
    input  logic                dec_syscall_in,
    input  logic                wb_valid_in,
    input  logic [REG_AW-1:0]   wb_rd_in,
    input  logic                pc_taken_in,
    output logic                stall_out,
    output logic                issue_valid_out,
    output logic                flush_out,
    output logic                drain_busy_out,
    output logic [NUM_REGS-1:0] pending_out
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    issue_state_e        state, state_next;
    logic [CNT_W-1:0]    flush_cnt, flush_cnt_next;
    logic                stall_raw, issue_raw;
    logic                hit_a, hit_b, hit_c;
    logic                hazard, sync_insn, run_pending;
    logic [NUM_REGS-1:0] pending_post_wb;

    reg_scoreboard #(
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .set_valid       (issue_valid_out),
        .set_rd          (dec_rd_in),
        .wb_valid        (wb_valid_in),
        .wb_rd           (wb_rd_in),
        .rd_a            (dec_rsa_in),
        .rd_b            (dec_rsb_in),
        .rd_c            (dec_rd_in),
        .hit_a           (hit_a),
        .hit_b           (hit_b),
        .hit_c           (hit_c),
        .pending         (pending_out),
        .pending_post_wb (pending_post_wb)
    );

    // Checking rd as well as the sources catches WAW.
    assign hazard    = dec_valid_in & (hit_a | hit_b | hit_c);
    assign sync_insn = dec_valid_in & (dec_memsync_in | dec_syscall_in);
    // Entering DRAIN uses the same wb-bypassed view as the hazard check, so
    // a sync instruction whose last outstanding write retires now just issues.
    assign run_pending = WB_BYPASS ? (|pending_post_wb) : (|pending_out);

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        stall_raw      = 1'b0;
        issue_raw      = 1'b0;
        case (state)
            ST_RUN: begin
                if (pc_taken_in) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (sync_insn && run_pending) begin
                    state_next = ST_DRAIN;
                    stall_raw  = 1'b1;
                end else if (hazard) begin
                    stall_raw = 1'b1;
                end else begin
                    issue_raw = dec_valid_in;
                end
            end
            ST_DRAIN: begin
                stall_raw = 1'b1;
                if (pc_taken_in) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (pending_post_wb == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Decode refills while flushing, so no stall here.
                if (pc_taken_in) begin
                    flush_cnt_next = FLUSH_LOAD;
                end else if (flush_cnt <= CNT_W'(1)) begin
                    state_next     = ST_RUN;
                    flush_cnt_next = '0;
                end else begin
                    flush_cnt_next = flush_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next     = ST_RUN;
                flush_cnt_next = '0;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign stall_out       = reset_in & stall_raw;
    assign issue_valid_out = reset_in & issue_raw;
    assign drain_busy_out  = (state == ST_DRAIN);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            flush_out <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            flush_out <= pc_taken_in;
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl_32.sv
// ---------------------------------------------------------------------------
// tb_decode_issue_ctrl_32
//  Directed stimulus with hand-computed expectations. Each applied vector
//  pushes its expected outputs into a queue; an independent monitor pops one
//  entry per cycle on the falling edge and compares every output.
// ---------------------------------------------------------------------------
module tb_decode_issue_ctrl_32;
    import fusion_pipe_pkg::*;

    logic                clk_in;
    logic                reset_in;
    logic                dec_valid_in;
    logic [REG_AW-1:0]   dec_rsa_in;
    logic [REG_AW-1:0]   dec_rsb_in;
    logic [REG_AW-1:0]   dec_rd_in;
    logic                dec_memsync_in;
    logic                dec_syscall_in;
    logic                wb_valid_in;
    logic [REG_AW-1:0]   wb_rd_in;
    logic                pc_taken_in;
    logic                stall_out;
    logic                issue_valid_out;
    logic                flush_out;
    logic                drain_busy_out;
    logic [NUM_REGS-1:0] pending_out;

    typedef struct {
        logic        stall;
        logic        issue;
        logic        flush;
        logic        drain;
        logic [31:0] pend;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    decode_issue_ctrl_32 #(
        .FLUSH_CYCLES (2),
        .WB_BYPASS    (1'b1)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .dec_valid_in    (dec_valid_in),
        .dec_rsa_in      (dec_rsa_in),
        .dec_rsb_in      (dec_rsb_in),
        .dec_rd_in       (dec_rd_in),
        .dec_memsync_in  (dec_memsync_in),
        .dec_syscall_in  (dec_syscall_in),
        .wb_valid_in     (wb_valid_in),
        .wb_rd_in        (wb_rd_in),
        .pc_taken_in     (pc_taken_in),
        .stall_out       (stall_out),
        .issue_valid_out (issue_valid_out),
        .flush_out       (flush_out),
        .drain_busy_out  (drain_busy_out),
        .pending_out     (pending_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", e.id, 32'(stall_out), 32'(e.stall));
                check("issue", e.id, 32'(issue_valid_out), 32'(e.issue));
                check("flush", e.id, 32'(flush_out), 32'(e.flush));
                check("drain", e.id, 32'(drain_busy_out), 32'(e.drain));
                check("pending", e.id, pending_out, e.pend);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected during that cycle.
    task automatic step(input logic rst, input logic v, input logic ms, input logic sc,
                        input logic [4:0] rsa, input logic [4:0] rsb, input logic [4:0] rd,
                        input logic wbv, input logic [4:0] wbr, input logic pct,
                        input logic e_st, input logic e_is, input logic e_fl,
                        input logic e_dr, input logic [31:0] e_pend);
        exp_t e;
        @(posedge clk_in);
        #1;
        reset_in       = rst;
        dec_valid_in   = v;
        dec_memsync_in = ms;
        dec_syscall_in = sc;
        dec_rsa_in     = rsa;
        dec_rsb_in     = rsb;
        dec_rd_in      = rd;
        wb_valid_in    = wbv;
        wb_rd_in       = wbr;
        pc_taken_in    = pct;
        e.stall = e_st;
        e.issue = e_is;
        e.flush = e_fl;
        e.drain = e_dr;
        e.pend  = e_pend;
        e.id    = vec_id;
        vec_id++;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_in       = 1'b0;
        dec_valid_in   = 1'b0;
        dec_memsync_in = 1'b0;
        dec_syscall_in = 1'b0;
        dec_rsa_in     = '0;
        dec_rsb_in     = '0;
        dec_rd_in      = '0;
        wb_valid_in    = 1'b0;
        wb_rd_in       = '0;
        pc_taken_in    = 1'b0;

        // Reset held with random inputs: every output must stay 0.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)),
                 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
                 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)),
                 1'($urandom_range(1, 0)),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end

        //   rst v  ms sc  rsa rsb rd  wbv wbr pct   st is fl dr pend
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,    0, 0, 0, 0, 32'h0);
        // RAW on r5: stall until wb of r5, issue in the wb cycle.
        step(1, 1, 0, 0,  1,  2,  5,  0,  0,  0,    0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0,  5,  0,  6,  0,  0,  0,    1, 0, 0, 0, 32'h20);
        step(1, 1, 0, 0,  5,  0,  6,  0,  0,  0,    1, 0, 0, 0, 32'h20);
        step(1, 1, 0, 0,  5,  0,  6,  1,  5,  0,    0, 1, 0, 0, 32'h20);
        step(1, 0, 0, 0,  0,  0,  0,  1,  9,  0,    0, 0, 0, 0, 32'h40);  // wb to non-pending r9
        step(1, 0, 0, 0,  0,  0,  0,  1,  6,  0,    0, 0, 0, 0, 32'h40);
        // WAW on r7 with same-cycle wb: issue wins, bit stays set.
        step(1, 1, 0, 0,  0,  0,  7,  0,  0,  0,    0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0,  0,  0,  7,  1,  7,  0,    0, 1, 0, 0, 32'h80);
        step(1, 1, 0, 0,  0,  0,  7,  0,  0,  0,    1, 0, 0, 0, 32'h80);
        step(1, 0, 0, 0,  0,  0,  0,  1,  7,  0,    0, 0, 0, 0, 32'h80);
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,    0, 0, 0, 0, 32'h0);
        // r0 traffic never stalls nor marks pending.
        step(1, 1, 0, 0,  0,  0,  0,  0,  0,  0,    0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0,  0,  0,  0,  1,  0,  0,    0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,    0, 0, 0, 0, 32'h0);
        // memsync drains r3 and r4, issues the cycle after DRAIN ends.
        step(1, 1, 0, 0,  0,  0,  3,  0,  0,  0,    0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0,  1,  0,  4,  0,  0,  0,    0, 1, 0, 0, 32'h8);
        step(1, 1, 1, 0,  0,  0,  0,  0,  0,  0,    1, 0, 0, 0, 32'h18);
        step(1, 1, 1, 0,  0,  0,  0,  1,  3,  0,    1, 0, 0, 1, 32'h18);
        step(1, 1, 1, 0,  0,  0,  0,  0,  0,  0,    1, 0, 0, 1, 32'h10);
        step(1, 1, 1, 0,  0,  0,  0,  1,  4,  0,    1, 0, 0, 1, 32'h10);
        step(1, 1, 1, 0,  0,  0,  0,  0,  0,  0,    0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,    0, 0, 0, 0, 32'h0);
        // Taken branch: flush pulse next cycle, two suppressed cycles.
        step(1, 1, 0, 0,  0,  0,  8,  0,  0,  1,    0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0,  0,  0,  8,  0,  0,  0,    0, 0, 1, 0, 32'h0);
        step(1, 1, 0, 0,  0,  0,  8,  0,  0,  0,    0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0,  0,  0,  8,  0,  0,  0,    0, 1, 0, 0, 32'h0);
        // Second taken branch mid-flush restarts the count at 2.
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  1,    0, 0, 0, 0, 32'h100);
        step(1, 1, 0, 0,  0,  0,  9,  0,  0,  1,    0, 0, 1, 0, 32'h100);
        step(1, 1, 0, 0,  0,  0,  9,  0,  0,  0,    0, 0, 1, 0, 32'h100);
        step(1, 1, 0, 0,  0,  0,  9,  0,  0,  0,    0, 0, 0, 0, 32'h100);
        step(1, 1, 0, 0,  0,  0,  9,  0,  0,  0,    0, 1, 0, 0, 32'h100);
        // syscall enters DRAIN, taken branch overrides into FLUSH.
        step(1, 1, 0, 1,  0,  0,  0,  0,  0,  0,    1, 0, 0, 0, 32'h300);
        step(1, 1, 0, 1,  0,  0,  0,  0,  0,  1,    1, 0, 0, 1, 32'h300);
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,    0, 0, 1, 0, 32'h300);
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,    0, 0, 0, 0, 32'h300);
        step(1, 0, 0, 0,  0,  0,  0,  1,  8,  0,    0, 0, 0, 0, 32'h300);
        step(1, 0, 0, 0,  0,  0,  0,  1,  9,  0,    0, 0, 0, 0, 32'h200);
        // Reset asserted mid-DRAIN: straight back to RUN, scoreboard clear.
        step(1, 1, 0, 0,  0,  0, 10,  0,  0,  0,    0, 1, 0, 0, 32'h0);
        step(1, 1, 1, 0,  0,  0,  0,  0,  0,  0,    1, 0, 0, 0, 32'h400);
        step(1, 1, 1, 0,  0,  0,  0,  0,  0,  0,    1, 0, 0, 1, 32'h400);
        step(0, 1, 1, 0,  0,  0,  0,  0,  0,  0,    0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0,  0,  0,  0,  0,  0,  0,    0, 0, 0, 0, 32'h0);
        step(1, 1, 1, 0,  0,  0,  0,  0,  0,  0,    0, 1, 0, 0, 32'h0);

        // Let the monitor consume the remaining expectations, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk_in);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
